// File: rtl/pcileech_ft601_responder.sv
// Device-side model of the FT601 245 synchronous FIFO bus, with a host push/pop port
// standing in for the USB host. The tristate bus is split into in/out/oe signals.
module pcileech_ft601_responder #(
  parameter int unsigned PARAM_DEPTH_LOG2  = 10,
  parameter int unsigned PARAM_BURST_WORDS = 1024,
  parameter int unsigned PARAM_GAP_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ft601_rst_n,
  input  logic [31:0] ft601_data_in,
  input  logic [3:0]  ft601_be_in,
  input  logic        ft601_wr_n,
  input  logic        ft601_rd_n,
  input  logic        ft601_oe_n,
  input  logic        ft601_siwu_n,
  output logic [31:0] ft601_data_out,
  output logic        ft601_data_oe,
  output logic        ft601_rxf_n,
  output logic        ft601_txe_n,
  input  logic        host_h2f_valid,
  input  logic [31:0] host_h2f_data,
  output logic        host_h2f_ready,
  output logic        host_f2h_valid,
  output logic [31:0] host_f2h_data,
  output logic [3:0]  host_f2h_be,
  input  logic        host_f2h_ready,
  output logic [15:0] err_rd_empty,
  output logic [15:0] err_wr_full
);

  localparam int unsigned Depth  = 1 << PARAM_DEPTH_LOG2;
  localparam int unsigned PtrW   = PARAM_DEPTH_LOG2;
  localparam int unsigned CntW   = PARAM_DEPTH_LOG2 + 1;
  localparam int unsigned BurstW = $clog2(PARAM_BURST_WORDS + 1);
  localparam int unsigned GapW   = $clog2(PARAM_GAP_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StBurst, StGap} rd_state_e;

  logic clr;
  assign clr = rst | ~ft601_rst_n;

  logic unused_siwu;
  assign unused_siwu = ft601_siwu_n;

  // Host-to-FPGA queue
  logic [31:0]     h2f_mem [Depth];
  logic [PtrW-1:0] h2f_wr_q, h2f_wr_d, h2f_rd_q, h2f_rd_d;
  logic [CntW-1:0] h2f_cnt_q, h2f_cnt_d;
  logic            h2f_empty, h2f_push, h2f_pop;

  // FPGA-to-host queue, {data, be} per entry
  logic [35:0]     f2h_mem [Depth];
  logic [35:0]     f2h_head;
  logic [PtrW-1:0] f2h_wr_q, f2h_wr_d, f2h_rd_q, f2h_rd_d;
  logic [CntW-1:0] f2h_cnt_q, f2h_cnt_d;
  logic            f2h_empty, f2h_full, f2h_push, f2h_pop, wr_req;

  rd_state_e         state_q, state_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              rxf_n_q, rxf_n_d;
  logic              txe_n_q, txe_n_d;
  logic              data_oe_q, data_oe_d;
  logic [15:0]       err_rd_q, err_rd_d, err_wr_q, err_wr_d;
  logic              rd_req;

  assign h2f_empty      = (h2f_cnt_q == '0);
  assign host_h2f_ready = ~clr & ~h2f_cnt_q[PARAM_DEPTH_LOG2];
  assign h2f_push       = host_h2f_valid & host_h2f_ready;
  assign rd_req         = ~ft601_rd_n & ~ft601_oe_n;
  assign h2f_pop        = (state_q == StBurst) & rd_req & ~h2f_empty;

  assign f2h_empty = (f2h_cnt_q == '0);
  assign f2h_full  = f2h_cnt_q[PARAM_DEPTH_LOG2];
  assign wr_req    = ~clr & ~ft601_wr_n;
  // txe_n is the registered value the FPGA is looking at right now
  assign f2h_push  = wr_req & ~txe_n_q & ~f2h_full;
  assign f2h_pop   = ~clr & host_f2h_ready & ~f2h_empty;

  always_comb begin
    h2f_wr_d  = h2f_wr_q;
    h2f_rd_d  = h2f_rd_q;
    h2f_cnt_d = h2f_cnt_q + CntW'(h2f_push) - CntW'(h2f_pop);
    if (h2f_push) h2f_wr_d = h2f_wr_q + PtrW'(1);
    if (h2f_pop)  h2f_rd_d = h2f_rd_q + PtrW'(1);
    f2h_wr_d  = f2h_wr_q;
    f2h_rd_d  = f2h_rd_q;
    f2h_cnt_d = f2h_cnt_q + CntW'(f2h_push) - CntW'(f2h_pop);
    if (f2h_push) f2h_wr_d = f2h_wr_q + PtrW'(1);
    if (f2h_pop)  f2h_rd_d = f2h_rd_q + PtrW'(1);
    if (clr) begin
      h2f_wr_d  = '0;
      h2f_rd_d  = '0;
      h2f_cnt_d = '0;
      f2h_wr_d  = '0;
      f2h_rd_d  = '0;
      f2h_cnt_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!h2f_empty) begin
          state_d     = StBurst;
          burst_cnt_d = '0;
        end
      end
      StBurst: begin
        if (h2f_pop) begin
          burst_cnt_d = burst_cnt_q + BurstW'(1);
          // A same-cycle host push keeps the burst alive when the last word leaves
          if ((burst_cnt_d == BurstW'(PARAM_BURST_WORDS)) ||
              ((h2f_cnt_q == CntW'(1)) && !h2f_push)) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q >= GapW'(PARAM_GAP_CYCLES - 1)) state_d = StIdle;
        else gap_cnt_d = gap_cnt_q + GapW'(1);
      end
      default: state_d = StIdle;
    endcase
    if (clr) begin
      state_d     = StIdle;
      burst_cnt_d = '0;
      gap_cnt_d   = '0;
    end
    rxf_n_d   = (state_d != StBurst);
    txe_n_d   = clr | (f2h_cnt_q > CntW'(Depth - 2));
    data_oe_d = ~clr & ~ft601_oe_n;

    err_rd_d = err_rd_q;
    err_wr_d = err_wr_q;
    if (clr) begin
      err_rd_d = '0;
      err_wr_d = '0;
    end else begin
      if (rd_req && h2f_empty && (err_rd_q != 16'hFFFF)) err_rd_d = err_rd_q + 16'd1;
      if (wr_req && !f2h_push && (err_wr_q != 16'hFFFF)) err_wr_d = err_wr_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    h2f_wr_q    <= h2f_wr_d;
    h2f_rd_q    <= h2f_rd_d;
    h2f_cnt_q   <= h2f_cnt_d;
    f2h_wr_q    <= f2h_wr_d;
    f2h_rd_q    <= f2h_rd_d;
    f2h_cnt_q   <= f2h_cnt_d;
    state_q     <= state_d;
    burst_cnt_q <= burst_cnt_d;
    gap_cnt_q   <= gap_cnt_d;
    rxf_n_q     <= rxf_n_d;
    txe_n_q     <= txe_n_d;
    data_oe_q   <= data_oe_d;
    err_rd_q    <= err_rd_d;
    err_wr_q    <= err_wr_d;
  end

  // Storage needs no reset; pointers and counts define validity
  always_ff @(posedge clk) begin
    if (h2f_push) h2f_mem[h2f_wr_q] <= host_h2f_data;
    if (f2h_push) f2h_mem[f2h_wr_q] <= {ft601_data_in, ft601_be_in};
  end

  assign f2h_head       = f2h_mem[f2h_rd_q];
  assign ft601_data_out = h2f_empty ? 32'd0 : h2f_mem[h2f_rd_q];
  assign ft601_data_oe  = data_oe_q;
  assign ft601_rxf_n    = rxf_n_q;
  assign ft601_txe_n    = txe_n_q;
  assign host_f2h_valid = ~f2h_empty;
  assign host_f2h_data  = f2h_head[35:4];
  assign host_f2h_be    = f2h_head[3:0];
  assign err_rd_empty   = err_rd_q;
  assign err_wr_full    = err_wr_q;

endmodule

// File: tb/tb_pcileech_ft601_responder.sv
// Bench for pcileech_ft601_responder: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the bus rules.
module tb_pcileech_ft601_responder;

  localparam int unsigned DepthLog2 = 2;
  localparam int unsigned Depth     = 4;
  localparam int unsigned Burst     = 3;
  localparam int unsigned Gap       = 4;

  logic        clk = 1'b0;
  logic        rst, ft601_rst_n;
  logic [31:0] ft601_data_in;
  logic [3:0]  ft601_be_in;
  logic        ft601_wr_n, ft601_rd_n, ft601_oe_n, ft601_siwu_n;
  logic [31:0] ft601_data_out;
  logic        ft601_data_oe, ft601_rxf_n, ft601_txe_n;
  logic        host_h2f_valid, host_h2f_ready;
  logic [31:0] host_h2f_data;
  logic        host_f2h_valid, host_f2h_ready;
  logic [31:0] host_f2h_data;
  logic [3:0]  host_f2h_be;
  logic [15:0] err_rd_empty, err_wr_full;

  always #5 clk = ~clk;

  pcileech_ft601_responder #(
    .PARAM_DEPTH_LOG2 (DepthLog2),
    .PARAM_BURST_WORDS(Burst),
    .PARAM_GAP_CYCLES (Gap)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ft601_rst_n   (ft601_rst_n),
    .ft601_data_in (ft601_data_in),
    .ft601_be_in   (ft601_be_in),
    .ft601_wr_n    (ft601_wr_n),
    .ft601_rd_n    (ft601_rd_n),
    .ft601_oe_n    (ft601_oe_n),
    .ft601_siwu_n  (ft601_siwu_n),
    .ft601_data_out(ft601_data_out),
    .ft601_data_oe (ft601_data_oe),
    .ft601_rxf_n   (ft601_rxf_n),
    .ft601_txe_n   (ft601_txe_n),
    .host_h2f_valid(host_h2f_valid),
    .host_h2f_data (host_h2f_data),
    .host_h2f_ready(host_h2f_ready),
    .host_f2h_valid(host_f2h_valid),
    .host_f2h_data (host_f2h_data),
    .host_f2h_be   (host_f2h_be),
    .host_f2h_ready(host_f2h_ready),
    .err_rd_empty  (err_rd_empty),
    .err_wr_full   (err_wr_full)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain queues, a burst flag, a word count and a gap countdown
  logic [31:0] m_hq[$];
  logic [35:0] m_fq[$];
  bit          m_oe, m_rxf, m_txe, m_in_burst, m_pushed;
  int unsigned m_err_rd, m_err_wr, m_burst_n, m_gap_left;

  task automatic model_step();
    int unsigned hc, fc;
    bit push, pop, rd_req;
    hc = m_hq.size();
    fc = m_fq.size();
    m_pushed = 1'b0;
    if (rst || !ft601_rst_n) begin
      m_hq.delete();
      m_fq.delete();
      m_oe = 0; m_rxf = 1; m_txe = 1; m_in_burst = 0;
      m_err_rd = 0; m_err_wr = 0; m_burst_n = 0; m_gap_left = 0;
      return;
    end
    push   = host_h2f_valid && (hc < Depth);
    rd_req = !ft601_rd_n && !ft601_oe_n;
    pop    = m_in_burst && rd_req && (hc > 0);
    if (rd_req && hc == 0 && m_err_rd < 16'hFFFF) m_err_rd++;
    if (m_in_burst) begin
      if (pop) begin
        m_burst_n++;
        if (m_burst_n == Burst || (hc == 1 && !push)) begin
          m_in_burst = 0;
          m_gap_left = Gap;
        end
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (hc > 0) begin
      m_in_burst = 1;
      m_burst_n  = 0;
    end
    m_rxf = !m_in_burst;
    if (pop) void'(m_hq.pop_front());
    if (push) m_hq.push_back(host_h2f_data);
    m_pushed = push;
    if (host_f2h_ready && fc > 0) void'(m_fq.pop_front());
    if (!ft601_wr_n) begin
      if (!m_txe && fc < Depth) m_fq.push_back({ft601_data_in, ft601_be_in});
      else if (m_err_wr < 16'hFFFF) m_err_wr++;
    end
    m_txe = !((Depth - fc) >= 2);
    m_oe  = !ft601_oe_n;
  endtask

  task automatic check_outputs();
    logic [35:0] fhead;
    check_eq("rxf_n", ft601_rxf_n, m_rxf);
    check_eq("txe_n", ft601_txe_n, m_txe);
    check_eq("data_oe", ft601_data_oe, m_oe);
    check_eq("data_out", ft601_data_out, (m_hq.size() > 0) ? m_hq[0] : 32'd0);
    check_eq("h2f_ready", host_h2f_ready,
             (!(rst || !ft601_rst_n) && m_hq.size() < Depth) ? 1'b1 : 1'b0);
    check_eq("f2h_valid", host_f2h_valid, (m_fq.size() > 0) ? 1'b1 : 1'b0);
    if (m_fq.size() > 0) begin
      fhead = m_fq[0];
      check_eq("f2h_data", host_f2h_data, fhead[35:4]);
      check_eq("f2h_be", host_f2h_be, fhead[3:0]);
    end
    check_eq("err_rd_empty", err_rd_empty, m_err_rd);
    check_eq("err_wr_full", err_wr_full, m_err_wr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic wait_rxf_low();
    for (int i = 0; i < 20 && ft601_rxf_n; i++) tick();
    check_eq("rxf_wait", ft601_rxf_n, 1'b0);
  endtask

  initial begin
    int unsigned sent;
    rst = 1; ft601_rst_n = 1; ft601_data_in = '0; ft601_be_in = '0;
    ft601_wr_n = 1; ft601_rd_n = 1; ft601_oe_n = 1; ft601_siwu_n = 1;
    host_h2f_valid = 0; host_h2f_data = '0; host_f2h_ready = 0;
    m_rxf = 1; m_txe = 1;
    repeat (2) tick();

    // Reset with both queues part-filled
    rst = 0; host_h2f_valid = 1; ft601_wr_n = 0; ft601_be_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      host_h2f_data = $urandom; ft601_data_in = $urandom;
      tick();
    end
    host_h2f_valid = 0; ft601_wr_n = 1; rst = 1;
    repeat (3) tick();
    rst = 0;
    #1;
    check_eq("rst_rxf_n", ft601_rxf_n, 1'b1);
    check_eq("rst_txe_n", ft601_txe_n, 1'b1);
    check_eq("rst_data_oe", ft601_data_oe, 1'b0);
    check_eq("rst_data_out", ft601_data_out, 32'd0);
    check_eq("rst_f2h_valid", host_f2h_valid, 1'b0);
    check_eq("rst_err_rd", err_rd_empty, 16'd0);
    check_eq("rst_err_wr", err_wr_full, 16'd0);
    check_eq("rst_h2f_ready", host_h2f_ready, 1'b1);

    // Read underflow: one word, three read cycles
    host_h2f_valid = 1; host_h2f_data = 32'h11111001;
    tick();
    host_h2f_valid = 0;
    wait_rxf_low();
    check_eq("uf_head", ft601_data_out, 32'h11111001);
    ft601_oe_n = 0; ft601_rd_n = 0;
    repeat (3) tick();
    ft601_rd_n = 1; ft601_oe_n = 1;
    check_eq("uf_err_rd", err_rd_empty, 16'd2);
    check_eq("uf_data_oe", ft601_data_oe, 1'b1);
    check_eq("uf_empty", ft601_data_out, 32'd0);
    repeat (6) tick();

    // f2h overflow: six back-to-back writes into a 4-deep queue
    for (int i = 0; i < 6; i++) begin
      ft601_wr_n = 0; ft601_data_in = 32'h22220000 + 32'(i); ft601_be_in = 4'(i + 1);
      tick();
    end
    ft601_wr_n = 1;
    check_eq("full_err_wr", err_wr_full, 16'd2);
    check_eq("full_txe_n", ft601_txe_n, 1'b1);
    host_f2h_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_data", host_f2h_data, 32'h22220000 + 32'(i));
      check_eq("drain_be", host_f2h_be, 4'(i + 1));
      tick();
    end
    check_eq("drain_empty", host_f2h_valid, 1'b0);
    host_f2h_ready = 0;

    // Streaming reads across several bursts and gaps
    sent = 0; ft601_oe_n = 0; ft601_rd_n = 0;
    for (int c = 0; c < 60; c++) begin
      host_h2f_valid = (sent < 12);
      host_h2f_data  = 32'h33330000 + 32'(sent);
      tick();
      if (m_pushed) sent++;
    end
    host_h2f_valid = 0; ft601_oe_n = 1; ft601_rd_n = 1;
    check_eq("stream_drained", ft601_data_out, 32'd0);
    check_eq("stream_rxf_n", ft601_rxf_n, 1'b1);

    // Chip reset pulse in the middle of a burst
    host_h2f_valid = 1;
    for (int i = 0; i < 3; i++) begin
      host_h2f_data = 32'h55550000 + 32'(i);
      tick();
    end
    host_h2f_valid = 0;
    wait_rxf_low();
    ft601_oe_n = 0; ft601_rd_n = 0;
    tick();
    ft601_rst_n = 0;
    tick();
    ft601_rst_n = 1; ft601_rd_n = 1; ft601_oe_n = 1;
    #1;
    check_eq("clr_rxf_n", ft601_rxf_n, 1'b1);
    check_eq("clr_data_out", ft601_data_out, 32'd0);
    check_eq("clr_data_oe", ft601_data_oe, 1'b0);
    check_eq("clr_h2f_ready", host_h2f_ready, 1'b1);
    host_h2f_valid = 1; host_h2f_data = 32'h44444444;
    tick();
    host_h2f_valid = 0;
    check_eq("refill_head", ft601_data_out, 32'h44444444);

    // Random traffic on both paths
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      ft601_rst_n    = ($urandom_range(0, 299) != 0);
      host_h2f_valid = $urandom_range(0, 1) == 1;
      host_h2f_data  = $urandom;
      ft601_oe_n     = ($urandom_range(0, 3) == 0);
      ft601_rd_n     = ($urandom_range(0, 2) == 0);
      ft601_wr_n     = $urandom_range(0, 1) == 1;
      ft601_data_in  = $urandom;
      ft601_be_in    = 4'($urandom);
      host_f2h_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
